// File: rtl/reflet_float_to_int_pkg.sv
// Shared definitions for the float-to-int converter: float field geometry
// helpers and the controller state encoding.
package reflet_float_to_int_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_SHIFT,
        ST_SIGN,
        ST_DONE
    } state_t;

    // Exponent field width for the supported float formats.
    function automatic int exponent_size(input int fs);
        case (fs)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    // Stored mantissa width (hidden leading 1 not included).
    function automatic int mantissa_size(input int fs);
        case (fs)
            16:      return 10;
            64:      return 52;
            default: return 23;
        endcase
    endfunction

    // Exponent bias.
    function automatic int exponent_bias(input int fs);
        case (fs)
            16:      return 15;
            64:      return 1023;
            default: return 127;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reflet_float_to_int_shifter.sv
// Serial one-bit-per-cycle shifter: a magnitude register, a shift counter
// and a latched direction. Only the low OUT_W bits are exposed.
module reflet_float_to_int_shifter #(
    parameter int W     = 24,
    parameter int CW    = 6,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_dir_left,
    input  logic [W-1:0]     i_mag,
    input  logic [CW-1:0]    i_cnt,
    output logic [OUT_W-1:0] o_mag,
    output logic             o_zero
);

    logic [W-1:0]  r_mag;
    logic [CW-1:0] r_cnt;
    logic          r_left;

    // Load a new operand, or move one bit per enabled cycle until cnt hits 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag  <= '0;
            r_cnt  <= '0;
            r_left <= 1'b0;
        end else if (i_load) begin
            r_mag  <= i_mag;
            r_cnt  <= i_cnt;
            r_left <= i_dir_left;
        end else if (i_shift && (r_cnt != '0)) begin
            // Zero fill both ways; right shift therefore truncates toward zero.
            r_mag <= r_left ? {r_mag[W-2:0], 1'b0} : {1'b0, r_mag[W-1:1]};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_mag  = r_mag[OUT_W-1:0];
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reflet_float_to_int.sv
// Multi-cycle packed-float to signed-integer converter with valid/ready on
// both sides. Magnitude alignment uses a serial shifter to keep area small;
// rounding is truncation toward zero, out-of-range values saturate.
module reflet_float_to_int
    import reflet_float_to_int_pkg::*;
#(
    parameter int int_size   = 16,
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [float_size-1:0] float_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [int_size-1:0]   int_out,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int E    = exponent_size(float_size);
    localparam int M    = mantissa_size(float_size);
    localparam int BIAS = exponent_bias(float_size);
    localparam int W    = max_int(M + 1, int_size);
    localparam int CW   = $clog2(max_int(M, int_size)) + 1;

    localparam logic [int_size-1:0] SAT_POS = {1'b0, {(int_size-1){1'b1}}};
    localparam logic [int_size-1:0] SAT_NEG = {1'b1, {(int_size-1){1'b0}}};

    state_t                r_state, w_next;
    logic [float_size-1:0] r_float;
    logic [int_size-1:0]   r_int;
    logic                  r_ovf, r_inv;

    logic                  w_sign;
    logic [E-1:0]          w_exp;
    logic [M-1:0]          w_mant;
    int                    w_e;
    logic                  w_exp_max, w_mant_zero;
    logic                  w_nan, w_inf, w_small, w_big, w_special;
    logic [CW-1:0]         w_cnt;
    logic [W-1:0]          w_mag_load;
    logic [int_size-1:0]   w_sat, w_mag;
    logic                  w_load, w_shift, w_zero;

    // Field decode of the registered operand.
    assign w_sign      = r_float[float_size-1];
    assign w_exp       = r_float[float_size-2 -: E];
    assign w_mant      = r_float[M-1:0];
    assign w_e         = int'(w_exp) - BIAS;
    assign w_exp_max   = &w_exp;
    assign w_mant_zero = (w_mant == '0);

    // Classification, checked in priority order by the data path.
    assign w_nan     = w_exp_max & ~w_mant_zero;
    assign w_inf     = w_exp_max & w_mant_zero;
    assign w_small   = (w_e < 0);
    // e == int_size-1 only fits for exactly -2^(int_size-1).
    assign w_big     = (w_e > int_size - 1) ||
                       ((w_e == int_size - 1) && !(w_sign && w_mant_zero));
    assign w_special = w_exp_max | w_small | w_big;

    assign w_cnt      = CW'((w_e < M) ? (M - w_e) : (w_e - M));
    assign w_mag_load = W'({1'b1, w_mant});
    assign w_sat      = w_sign ? SAT_NEG : SAT_POS;

    reflet_float_to_int_shifter #(
        .W     (W),
        .CW    (CW),
        .OUT_W (int_size)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_dir_left (w_e > M),
        .i_mag      (w_mag_load),
        .i_cnt      (w_cnt),
        .o_mag      (w_mag),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and shifter control.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            ST_IDLE:     if (in_valid) w_next = ST_CLASSIFY;
            ST_CLASSIFY: begin
                if (w_special) begin
                    w_next = ST_DONE;
                end else begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_zero) w_next = ST_SIGN;
                else        w_shift = 1'b1;
            end
            ST_SIGN:     w_next = ST_DONE;
            ST_DONE:     if (out_ready) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Operand capture, result and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_float <= '0;
            r_int   <= '0;
            r_ovf   <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) r_float <= float_in;
                ST_CLASSIFY: begin
                    if (w_nan) begin
                        r_int <= '0;
                        r_inv <= 1'b1;
                    end else if (w_inf) begin
                        r_int <= w_sat;
                        r_ovf <= 1'b1;
                    end else if (w_small) begin
                        r_int <= '0;
                    end else if (w_big) begin
                        r_int <= w_sat;
                        r_ovf <= 1'b1;
                    end
                end
                ST_SIGN: r_int <= w_sign ? -w_mag : w_mag;
                ST_DONE: begin
                    if (out_ready) begin
                        r_ovf <= 1'b0;
                        r_inv <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign int_out   = r_int;
    assign overflow  = r_ovf;
    assign invalid   = r_inv;

endmodule
